// File: rtl/adder_share_ctrl.sv
// Arbitrates N requesters onto one 32-bit carry-lookahead adder; 64-bit ops take two passes.
// Optional subtract support is enabled by defining ALU_SUB_EN.
module adder_share_ctrl #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N-1:0]     req_wide,
  input  logic [N-1:0]     req_sub,
  input  logic [64*N-1:0]  req_a,
  input  logic [64*N-1:0]  req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IDW-1:0]   resp_id,
  output logic [63:0]      resp_sum,
  output logic             resp_carry
);

`ifdef ALU_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [63:0]    a_lat_q, a_lat_d, b_lat_q, b_lat_d;
  logic           wide_q, wide_d, sub_q, sub_d;
  logic [63:0]    resp_sum_q, resp_sum_d;
  logic           resp_carry_q, resp_carry_d;
  logic           carry_reg_q, carry_reg_d;

  logic [N-1:0]   hi_mask, sel_vec;
  logic           grant_valid;
  logic [IDW-1:0] grant_idx;
  logic [63:0]    a_sel, b_sel;
  logic           wide_sel, sub_sel, sub_eff;

  logic [31:0]    add_a, add_b, add_s, bit_g, bit_p, bit_c;
  logic           add_c0, add_co;
  logic [8:0]     grp_c;

  genvar gi;

  // Requesters at or above the pointer win first; otherwise wrap to the lowest index.
  for (gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = req_valid[gi] & (gi >= int'(rr_ptr_q));
  end

  assign grant_valid = |req_valid;

  always_comb begin
    sel_vec   = (hi_mask != '0) ? hi_mask : req_valid;
    grant_idx = '0;
    a_sel     = '0;
    b_sel     = '0;
    wide_sel  = 1'b0;
    sub_sel   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (sel_vec[k]) begin
        grant_idx = IDW'(k);
        a_sel     = req_a[64*k +: 64];
        b_sel     = req_b[64*k +: 64];
        wide_sel  = req_wide[k];
        sub_sel   = req_sub[k];
      end
    end
  end

  assign sub_eff = sub_q & SUB_EN;

  always_comb begin
    add_a  = a_lat_q[31:0];
    add_b  = b_lat_q[31:0] ^ {32{sub_eff}};
    add_c0 = sub_eff;
    if (state_q == HI) begin
      add_a  = a_lat_q[63:32];
      add_b  = b_lat_q[63:32] ^ {32{sub_eff}};
      add_c0 = carry_reg_q;
    end
  end

  // Shared adder: 4-bit lookahead groups chained on group generate/propagate.
  assign bit_g    = add_a & add_b;
  assign bit_p    = add_a ^ add_b;
  assign grp_c[0] = add_c0;

  for (gi = 0; gi < 8; gi++) begin : g_cla
    localparam int B = 4 * gi;
    assign bit_c[B]   = grp_c[gi];
    assign bit_c[B+1] = bit_g[B] | (bit_p[B] & grp_c[gi]);
    assign bit_c[B+2] = bit_g[B+1] | (bit_p[B+1] & bit_g[B])
                      | (bit_p[B+1] & bit_p[B] & grp_c[gi]);
    assign bit_c[B+3] = bit_g[B+2] | (bit_p[B+2] & bit_g[B+1])
                      | (bit_p[B+2] & bit_p[B+1] & bit_g[B])
                      | (bit_p[B+2] & bit_p[B+1] & bit_p[B] & grp_c[gi]);
    assign grp_c[gi+1] = bit_g[B+3] | (bit_p[B+3] & bit_g[B+2])
                       | (bit_p[B+3] & bit_p[B+2] & bit_g[B+1])
                       | (bit_p[B+3] & bit_p[B+2] & bit_p[B+1] & bit_g[B])
                       | (bit_p[B+3] & bit_p[B+2] & bit_p[B+1] & bit_p[B] & grp_c[gi]);
  end

  assign add_s  = bit_p ^ bit_c;
  assign add_co = grp_c[8];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    a_lat_d      = a_lat_q;
    b_lat_d      = b_lat_q;
    wide_d       = wide_q;
    sub_d        = sub_q;
    resp_sum_d   = resp_sum_q;
    resp_carry_d = resp_carry_q;
    carry_reg_d  = carry_reg_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_ready = N'(1) << grant_idx;
          id_d      = grant_idx;
          a_lat_d   = a_sel;
          b_lat_d   = b_sel;
          wide_d    = wide_sel;
          sub_d     = sub_sel;
          state_d   = LO;
        end
      end
      LO: begin
        resp_sum_d[31:0] = add_s;
        carry_reg_d      = add_co;
        if (wide_q) begin
          state_d = HI;
        end else begin
          resp_sum_d[63:32] = '0;
          resp_carry_d      = add_co;
          state_d           = RESP;
        end
      end
      HI: begin
        resp_sum_d[63:32] = add_s;
        resp_carry_d      = add_co;
        state_d           = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          rr_ptr_d = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      a_lat_q      <= '0;
      b_lat_q      <= '0;
      wide_q       <= 1'b0;
      sub_q        <= 1'b0;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
      carry_reg_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      a_lat_q      <= a_lat_d;
      b_lat_q      <= b_lat_d;
      wide_q       <= wide_d;
      sub_q        <= sub_d;
      resp_sum_q   <= resp_sum_d;
      resp_carry_q <= resp_carry_d;
      carry_reg_q  <= carry_reg_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_carry = resp_carry_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: directed literal cases plus random traffic against a
// cycle-level transaction model. Honours ALU_SUB_EN the same way as the design.
module tb_adder_share_ctrl;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_wide, req_sub;
  logic [64*N-1:0] req_a, req_b;
  logic            resp_valid, resp_ready, resp_carry;
  logic [IDW-1:0]  resp_id;
  logic [63:0]     resp_sum;

  always #5 clk = ~clk;

  adder_share_ctrl #(.N(N), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wide(req_wide), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_carry(resp_carry)
  );

  int   n_vec = 0;
  int   n_err = 0;
  logic checking = 1'b0;

  // Transaction model: one op in flight, counted down to its response cycle.
  logic        m_busy = 1'b0;
  int          m_wait = 0;
  int          m_ptr = 0;
  int          m_id = 0;
  logic [63:0] m_sum = '0;
  logic        m_carry = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic void model_calc(input int i, output logic [63:0] s, output logic c);
    logic [63:0] a, b;
    logic        sb;
    logic [64:0] w;
    logic [32:0] n;
    a  = req_a[64*i +: 64];
    b  = req_b[64*i +: 64];
    sb = 1'b0;
`ifdef ALU_SUB_EN
    sb = req_sub[i];
`endif
    if (sb) b = ~b;
    if (req_wide[i]) begin
      w = {1'b0, a} + {1'b0, b} + {64'd0, sb};
      s = w[63:0];
      c = w[64];
    end else begin
      n = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, sb};
      s = {32'd0, n[31:0]};
      c = n[32];
    end
  endfunction

  always @(posedge clk) begin : mdl
    int g;
    logic [63:0] s;
    logic c;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_ptr  <= 0;
      m_wait <= 0;
    end else if (!m_busy) begin
      g = model_grant();
      if (g >= 0) begin
        model_calc(g, s, c);
        m_busy  <= 1'b1;
        m_id    <= g;
        m_wait  <= req_wide[g] ? 2 : 1;
        m_sum   <= s;
        m_carry <= c;
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
    end else if (resp_ready) begin
      m_busy <= 1'b0;
      m_ptr  <= (m_id + 1) % N;
    end
  end

  always @(negedge clk) begin : cmp
    int g;
    logic [N-1:0] er;
    logic ev;
    if (checking && rst_n) begin
      g  = model_grant();
      er = (!m_busy && g >= 0) ? (N'(1) << g) : '0;
      ev = m_busy && (m_wait == 0);
      check("req_ready", 64'(req_ready), 64'(er));
      check("resp_valid", 64'(resp_valid), 64'(ev));
      if (ev) begin
        check("resp_id", 64'(resp_id), 64'(m_id));
        check("resp_sum", resp_sum, m_sum);
        check("resp_carry", 64'(resp_carry), 64'(m_carry));
      end
    end
  end

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 50);
    if (!resp_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_timeout: no resp_valid after %0d cycles", lat);
    end
  endtask

  task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b,
                       input logic w, input logic s, output int lat);
    int n;
    @(posedge clk);
    #1;
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
    req_wide[i]  = w;
    req_sub[i]   = s;
    req_valid[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 50);
    if (!req_ready[i]) begin
      n_vec++;
      n_err++;
      $display("FAIL grant_timeout: requester %0d got ready 0 expected 1", i);
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    wait_resp(lat);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat, n, k;
    int got[5];
    int exp_order[5];
    logic [N-1:0] seen;
    req_valid = '0; req_wide = '0; req_sub = '0; req_a = '0; req_b = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;

    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_sum", resp_sum, 64'd0);
    check("rst_resp_carry", 64'(resp_carry), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);

    issue(0, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0, lat);
    check("narrow_lat", 64'(lat), 64'd2);
    check("narrow_sum", resp_sum, 64'h0);
    check("narrow_carry", 64'(resp_carry), 64'd1);
    check("narrow_id", 64'(resp_id), 64'd0);

    issue(2, 64'h00000000_FFFFFFFF, 64'h1, 1'b1, 1'b0, lat);
    check("wide_lat", 64'(lat), 64'd3);
    check("wide_sum", resp_sum, 64'h00000001_00000000);
    check("wide_carry", 64'(resp_carry), 64'd0);
    check("wide_id", 64'(resp_id), 64'd2);

    issue(2, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, lat);
    check("wide_ones_sum", resp_sum, 64'hFFFFFFFF_FFFFFFFE);
    check("wide_ones_carry", 64'(resp_carry), 64'd1);

    issue(2, 64'h00000001_00000000, 64'h1, 1'b1, 1'b1, lat);
`ifdef ALU_SUB_EN
    check("sub1_sum", resp_sum, 64'h00000000_FFFFFFFF);
    check("sub1_carry", 64'(resp_carry), 64'd1);
`else
    check("sub1_sum", resp_sum, 64'h00000001_00000001);
    check("sub1_carry", 64'(resp_carry), 64'd0);
`endif
    issue(2, 64'h0, 64'h1, 1'b1, 1'b1, lat);
`ifdef ALU_SUB_EN
    check("sub2_sum", resp_sum, 64'hFFFFFFFF_FFFFFFFF);
`else
    check("sub2_sum", resp_sum, 64'h1);
`endif
    check("sub2_carry", 64'(resp_carry), 64'd0);

    // Backpressure: response from requester 1 held while requester 2 waits.
    @(posedge clk);
    #1 resp_ready = 1'b0;
    issue(1, 64'h10, 64'h20, 1'b0, 1'b0, lat);
    @(posedge clk);
    #1;
    req_a[128 +: 64] = 64'h5; req_b[128 +: 64] = 64'h7; req_wide[2] = 1'b0; req_sub[2] = 1'b0;
    req_valid[2] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_sum", resp_sum, 64'h30);
      check("bp_id", 64'(resp_id), 64'd1);
      check("bp_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_next_grant", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    wait_resp(lat);
    check("bp_next_sum", resp_sum, 64'hC);
    check("bp_next_id", 64'(resp_id), 64'd2);

    // Reset during the HI pass of a wide op from requester 3.
    @(posedge clk);
    #1;
    req_a[192 +: 64] = 64'h1234; req_b[192 +: 64] = 64'h1; req_wide[3] = 1'b1; req_valid[3] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[3] && n < 20);
    check("midrst_grant", 64'(req_ready[3]), 64'd1);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(resp_valid), 64'd0);
    check("midrst_sum", resp_sum, 64'd0);
    check("midrst_id", 64'(resp_id), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_stale", 64'(resp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    req_a[64 +: 64] = 64'h9; req_b[64 +: 64] = 64'h1; req_wide[1] = 1'b0;
    req_valid[1] = 1'b1; req_valid[3] = 1'b1;
    @(negedge clk);
    check("midrst_ptr_grant", 64'(req_ready), 64'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    wait_resp(lat);
    check("midrst_after_sum", resp_sum, 64'hA);

    // Round robin with every requester asserting continuously from reset.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[64*i +: 64] = {$urandom, $urandom};
      req_b[64*i +: 64] = {$urandom, $urandom};
      req_wide[i] = 1'b0;
    end
    req_valid = '1;
    exp_order = '{0, 1, 2, 3, 0};
    for (int j = 0; j < 5; j++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready == '0 && n < 20);
      got[j] = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) got[j] = i;
      check("rr_order", 64'(got[j]), 64'(exp_order[j]));
      k = (got[j] < 0) ? 0 : got[j];
      @(posedge clk);
      #1;
      req_a[64*k +: 64] = {$urandom, $urandom};
      req_wide[k] = $urandom_range(0, 1) == 1;
    end
    req_valid = '0;

    // Random traffic, all checking done by the model compare process.
    seen = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ((req_valid[i] && seen[i]) || (!req_valid[i] && $urandom_range(0, 2) == 0)) begin
          req_valid[i] = $urandom_range(0, 1) == 1;
          req_a[64*i +: 64] = ($urandom_range(0, 3) == 0) ? 64'hFFFFFFFF_FFFFFFFF : {$urandom, $urandom};
          req_b[64*i +: 64] = ($urandom_range(0, 3) == 0) ? 64'h1 : {$urandom, $urandom};
          req_wide[i] = $urandom_range(0, 1) == 1;
          req_sub[i]  = $urandom_range(0, 1) == 1;
        end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      seen = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Shares one 32-bit carry-lookahead adder (c0 carry-in, carry-out) among N requesters.
- Each requester issues a 32-bit or 64-bit add. 64-bit ops run as two sequenced passes through the adder, with the carry held in a register.
- Round-robin arbitration, valid/ready request handshake, one registered response channel tagged with requester id.
- Sits between the ALU front-end clients and the shared adder32 instance.

Parameters:
- N, 4, number of requesters (2..8)
- IDW, 2, response id width; must satisfy 2**IDW >= N

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester accept strobe (combinational)
- req_wide  in  N  1 = 64-bit op, 0 = 32-bit op
- req_sub  in  N  subtract select (see Optional Feature)
- req_a  in  64*N  operand A; requester i uses bits [64i+63:64i]; upper 32 ignored when narrow
- req_b  in  64*N  operand B, same packing
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_id  out  IDW  index of the requester that owns the result
- resp_sum  out  64  result; bits [63:32] = 0 for narrow ops
- resp_carry  out  1  carry-out of the final pass

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, rr_ptr=0, resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0, carry_reg=0, all operand latches 0. Reset mid-operation abandons the op; no response is produced.
- FSM states: IDLE, LO, HI, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N.
  - req_ready[grant]=1 only in IDLE with a valid grant; all other req_ready bits are 0.
  - On accept: latch a, b, wide, sub, and id; go to LO.
  - No valid requests: stay in IDLE.
- LO:
  - Adder inputs: a_lat[31:0], b_lat[31:0], c0=0.
  - Register sum into resp_sum[31:0] and carry-out into carry_reg.
  - wide=1: go to HI.
  - wide=0: resp_sum[63:32]=0, resp_carry=carry-out, go to RESP.
- HI:
  - Adder inputs: a_lat[63:32], b_lat[63:32], c0=carry_reg.
  - Register sum into resp_sum[63:32] and carry-out into resp_carry; go to RESP.
- RESP:
  - resp_valid=1; resp_id, resp_sum and resp_carry are held stable.
  - On resp_valid & resp_ready: resp_valid=0, rr_ptr=(id+1) mod N, go to IDLE.
  - Backpressure: stays in RESP indefinitely while resp_ready=0.
- Latency, accept edge = T: narrow response valid from edge T+2, wide from edge T+3.
  - Minimum issue interval is 3 cycles (narrow) or 4 cycles (wide), since the next accept happens in the IDLE cycle after the response handshake.
- Handshake rules:
  - A requester holds req_valid and its operands stable until req_ready is seen.
  - Deasserting req_valid before acceptance is legal; the request is simply not granted.
- Arithmetic: all sums are modulo 2^32 per pass and 2^64 overall; resp_carry is bit 64 (wide) or bit 32 (narrow).
- Simultaneous requests:
  - Round-robin guarantees each valid requester is served within N grants.
  - A requester served last has lowest priority next time.
- Only one operation is in flight; the adder inputs are don't-care in IDLE and RESP.

Optional Feature:
- Macro ALU_SUB_EN.
- Defined:
  - req_sub=1 selects A-B: LO pass uses ~b_lat[31:0] with c0=1; HI pass uses ~b_lat[63:32] with c0=carry_reg.
  - resp_carry=1 means no borrow.
- Undefined: the req_sub port still exists but is ignored; every op is an add.

Test Plan:
- Narrow add, req0: A=0x00000000_FFFFFFFF, B=0x1, wide=0 -> resp_valid 2 cycles after accept; resp_sum=0x00000000_00000000, resp_carry=1, resp_id=0.
- Wide add, req2: A=0x00000000_FFFFFFFF, B=0x1, wide=1 -> resp_sum=0x00000001_00000000, resp_carry=0, latency 3, id=2. Then A=B=0xFFFFFFFF_FFFFFFFF -> sum=0xFFFFFFFF_FFFFFFFE, carry=1.
- All 4 requesters valid continuously, rr_ptr=0 at reset -> grant order 0,1,2,3,0; each req_ready pulses for exactly 1 cycle.
- Backpressure: resp_ready=0 for 5 cycles during RESP -> resp fields stable, no req_ready asserted; resp_ready=1 -> IDLE, next grant follows.
- Reset mid-op: rst_n=0 during HI of a wide op -> next cycle state IDLE, resp_valid=0, rr_ptr=0, no stale response afterwards.
- ALU_SUB_EN defined, wide sub: A=0x1_00000000, B=0x1 -> sum=0x00000000_FFFFFFFF, carry=1. A=0, B=1 -> sum=0xFFFFFFFF_FFFFFFFF, carry=0. Undefined, same stimulus -> add results.
